// File: rtl/segment_scan.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Blanks between slots, double-buffers the value, optional zero blanking.
module segment_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_en,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  dp,
  output logic                  frame
);

  localparam int IW  = $clog2(DIGITS);
  localparam int CW  = $clog2(PRESCALE + 1);
  localparam int BL1 = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int SH1 = PRESCALE - BLANK - 1;
  localparam int VW  = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [VW-1:0]     pend_val;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_valid;
  logic [VW-1:0]     act_val;
  logic [DIGITS-1:0] act_dp;

  logic              last_show;
  logic              last_idx;
  logic              slot_start;
  logic              promote;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     tidx;
  logic [VW-1:0]     vbuf;
  logic [DIGITS-1:0] dbuf;
  logic [VW-1:0]     upper;
  logic [3:0]        nib;
  logic              supp;
  logic [DIGITS-1:0] lit;
  logic              lit_dp;

  // Output values are computed for the slot being entered, so the
  // buffer that is about to become active is used on a promotion.
  always_comb begin
    last_show  = (state == S_SHOW) && (cnt == CW'(SH1));
    last_idx   = (idx == IW'(DIGITS - 1));
    slot_start = enable && ((state == S_IDLE) || last_show);
    start_idx  = ((state == S_IDLE) || last_idx) ? '0 : idx + 1'b1;
    tidx       = slot_start ? start_idx : idx;
    promote    = slot_start && (start_idx == '0) && pend_valid;
    vbuf       = promote ? pend_val : act_val;
    dbuf       = promote ? pend_dp : act_dp;
    upper      = vbuf >> {tidx, 2'b00};
    nib        = upper[3:0];
    supp       = lz_en && (tidx != '0) && (upper == '0);
    lit        = supp ? '0 : (DIGITS'(1) << tidx);
    lit_dp     = !supp && dbuf[tidx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      bcd        <= '0;
      digit_en   <= '0;
      dp         <= 1'b0;
      frame      <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_mask;
      end
      if (load)
        pend_valid <= 1'b1;
      else if (promote)
        pend_valid <= 1'b0;
      if (promote) begin
        act_val <= vbuf;
        act_dp  <= dbuf;
      end
      if (!enable) begin
        state    <= S_IDLE;
        idx      <= '0;
        cnt      <= '0;
        bcd      <= '0;
        digit_en <= '0;
        dp       <= 1'b0;
      end else if (slot_start) begin
        idx   <= tidx;
        cnt   <= '0;
        bcd   <= nib;
        frame <= (state == S_SHOW) && last_idx;
        if (BLANK > 0) begin
          state    <= S_BLANK;
          digit_en <= '0;
          dp       <= 1'b0;
        end else begin
          state    <= S_SHOW;
          digit_en <= lit;
          dp       <= lit_dp;
        end
      end else if (state == S_BLANK) begin
        if (cnt == CW'(BL1)) begin
          state    <= S_SHOW;
          cnt      <= '0;
          digit_en <= lit;
          dp       <= lit_dp;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
